ft_tx_ctrl: RTL and testbench



---
 rtl/ft_tx_pkg.sv | 19 +
 rtl/ft_skid_buf.sv | 73 +++++++
 rtl/ft_tx_ctrl.sv | 178 +++++++++++++++++
 tb/tb_ft_tx_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft_tx_pkg.sv
// ft_tx_pkg: shared types and default constants for the FT232H transmit path.
//   - tx_state_e : transmit sequencer states
//   - FT_BYTE_W  : width of the FT232H data bus
//   - *_DEF      : default values for the ft_tx_ctrl / ft_skid_buf parameters
package ft_tx_pkg;

  localparam int FT_BYTE_W      = 8;
  localparam int SKID_DEPTH_DEF = 4;
  localparam int CNT_W_DEF      = 32;
  localparam int FLUSH_IDLE_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    PAUSE  = 2'd2,
    FLUSH  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/ft_skid_buf.sv
// ft_skid_buf: circular skid buffer holding bytes already read from the FIFO
// but not yet accepted by the FT232H.
//   clk_i        : clock
//   rst_ni       : asynchronous active-low reset (clears pointers/occupancy)
//   push_i       : write push_data_i at the tail this cycle
//   push_data_i  : byte to write
//   pop_i        : drop the head entry this cycle (ignored when empty)
//   occ_o        : current occupancy
//   occ_nxt_o    : occupancy after this cycle's push/pop
//   head_nxt_o   : head entry after this cycle's push/pop (valid when occ_nxt_o != 0)
module ft_skid_buf
  import ft_tx_pkg::*;
#(
  parameter int DEPTH = SKID_DEPTH_DEF,
  parameter int W     = FT_BYTE_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [W-1:0]           push_data_i,
  input  logic                   pop_i,
  output logic [$clog2(DEPTH):0] occ_o,
  output logic [$clog2(DEPTH):0] occ_nxt_o,
  output logic [W-1:0]           head_nxt_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d, occ_rem;
  logic          pop_ok;

  always_comb begin
    pop_ok   = pop_i & (occ_q != '0);
    wr_ptr_d = wr_ptr_q + AW'(push_i);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    occ_rem  = occ_q - (AW+1)'(pop_ok);
    occ_d    = occ_rem + (AW+1)'(push_i);
    // When the pop leaves nothing behind, the new head is the byte being
    // pushed right now; it is not in mem_q until the next edge.
    if (occ_rem == '0) begin
      head_nxt_o = push_data_i;
    end else begin
      head_nxt_o = mem_q[rd_ptr_d];
    end
  end

  assign occ_o     = occ_q;
  assign occ_nxt_o = occ_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage carries no reset: stale entries are unreachable once the
  // pointers and occupancy are cleared.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/ft_tx_ctrl.sv
// ft_tx_ctrl: drives the FT232H synchronous-245 write side from the read
// port of the ADC async FIFO. Bytes are prefetched into a small skid buffer
// so TXE# may toggle at any time without losing or repeating a byte.
//   ft_shift_clk : FT232H 60 MHz clock, the only clock of the block
//   rst_n        : asynchronous active-low reset
//   tx_en        : streaming enable
//   fifo_q       : FIFO read data, valid one cycle after fifo_rdreq
//   fifo_empty   : FIFO rdempty
//   fifo_rdreq   : FIFO read request
//   ft_txe_i     : FT232H TXE#, low when the device can take a byte
//   ft_adbus_o   : FT232H data bus
//   ft_wr_n_o    : FT232H WR#, active low
//   ft_siwu_n_o  : FT232H SIWU#, active low send-immediate pulse
//   tx_busy      : sequencer not in IDLE
//   tx_byte_cnt  : bytes accepted by the device since reset (wraps)
// Optional feature macro FT_SIWU_EN: after FLUSH_IDLE idle cycles in STREAM
// a single one-cycle SIWU# pulse is issued before returning to IDLE.
// Without it SIWU# is tied high and no idle timer exists.
module ft_tx_ctrl
  import ft_tx_pkg::*;
#(
  parameter int SKID_DEPTH = SKID_DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FLUSH_IDLE = FLUSH_IDLE_DEF
) (
  input  logic                 ft_shift_clk,
  input  logic                 rst_n,
  input  logic                 tx_en,
  input  logic [FT_BYTE_W-1:0] fifo_q,
  input  logic                 fifo_empty,
  output logic                 fifo_rdreq,
  input  logic                 ft_txe_i,
  output logic [FT_BYTE_W-1:0] ft_adbus_o,
  output logic                 ft_wr_n_o,
  output logic                 ft_siwu_n_o,
  output logic                 tx_busy,
  output logic [CNT_W-1:0]     tx_byte_cnt
);

  localparam int AW = $clog2(SKID_DEPTH);

  tx_state_e            state_q, state_d;
  logic                 inflight_q;
  logic [FT_BYTE_W-1:0] adbus_q, adbus_d;
  logic                 wr_n_q, wr_n_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [AW:0]          occ, occ_nxt;
  logic [FT_BYTE_W-1:0] head_nxt;
  logic                 accept;
  logic                 drained;

  ft_skid_buf #(
    .DEPTH (SKID_DEPTH),
    .W     (FT_BYTE_W)
  ) u_skid (
    .clk_i       (ft_shift_clk),
    .rst_ni      (rst_n),
    .push_i      (inflight_q),
    .push_data_i (fifo_q),
    .pop_i       (accept),
    .occ_o       (occ),
    .occ_nxt_o   (occ_nxt),
    .head_nxt_o  (head_nxt)
  );

  // A slot is reserved for every outstanding request, so the push that
  // follows a request can never overflow the buffer. rst_n gates the
  // request so the FIFO is never read while the block is held in reset.
  assign fifo_rdreq = rst_n & tx_en & ~fifo_empty &
                      ((int'(occ) + int'(inflight_q)) < SKID_DEPTH);

  assign accept  = ~wr_n_q & ~ft_txe_i;
  assign drained = (occ == '0) & ~inflight_q & (~tx_en | fifo_empty);

  always_comb begin
    wr_n_d  = (occ_nxt == '0);
    adbus_d = adbus_q;
    if (occ_nxt != '0) begin
      adbus_d = head_nxt;
    end
    cnt_d = cnt_q + CNT_W'(accept);
  end

`ifdef FT_SIWU_EN
  localparam int IC_W = $clog2(FLUSH_IDLE + 1);

  logic [IC_W-1:0] idle_cnt_q, idle_cnt_d;
  logic            flushed_q, flushed_d;
  logic            idle_done;

  assign idle_done = (idle_cnt_q == IC_W'(FLUSH_IDLE - 1));

  always_comb begin
    idle_cnt_d = '0;
    if ((state_q == STREAM) && drained) begin
      idle_cnt_d = idle_cnt_q + IC_W'(1);
    end
    // One flush per idle period: armed again only by the next accepted byte.
    flushed_d = flushed_q;
    if (accept) begin
      flushed_d = 1'b0;
    end else if (state_d == FLUSH) begin
      flushed_d = 1'b1;
    end
  end

  always_ff @(posedge ft_shift_clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
      flushed_q  <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      flushed_q  <= flushed_d;
    end
  end

  assign ft_siwu_n_o = (state_q != FLUSH);
`else
  assign ft_siwu_n_o = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (tx_en & ~fifo_empty) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (ft_txe_i && (occ != '0)) begin
          state_d = PAUSE;
        end else if (drained) begin
`ifdef FT_SIWU_EN
          if (flushed_q) begin
            state_d = IDLE;
          end else if (idle_done) begin
            state_d = FLUSH;
          end
`else
          state_d = IDLE;
`endif
        end
      end
      PAUSE: begin
        if (!ft_txe_i) begin
          state_d = STREAM;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ft_shift_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      adbus_q    <= '0;
      wr_n_q     <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rdreq;
      adbus_q    <= adbus_d;
      wr_n_q     <= wr_n_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ft_adbus_o  = adbus_q;
  assign ft_wr_n_o   = wr_n_q;
  assign tx_busy     = (state_q != IDLE);
  assign tx_byte_cnt = cnt_q;

endmodule

// File: tb/tb_ft_tx_ctrl.sv
// tb_ft_tx_ctrl: self-checking bench for ft_tx_ctrl. A behavioural FIFO
// feeds the DUT; every byte the device accepts must be the next byte that
// was written into that FIFO. A second instance with a 4-bit counter shares
// all inputs to exercise counter wrap.
module tb_ft_tx_ctrl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_en;
  logic [7:0] fifo_q;
  logic       fifo_empty;
  logic       fifo_rdreq;
  logic       ft_txe_i;
  logic [7:0] ft_adbus_o;
  logic       ft_wr_n_o;
  logic       ft_siwu_n_o;
  logic       tx_busy;
  logic [31:0] tx_byte_cnt;

  logic       rdreq4, wr_n4, siwu4, busy4;
  logic [7:0] adbus4;
  logic [3:0] cnt4;

  always #5 clk = ~clk;

  ft_tx_ctrl #(.SKID_DEPTH(DEPTH), .CNT_W(32), .FLUSH_IDLE(16)) dut (
    .ft_shift_clk (clk),
    .rst_n        (rst_n),
    .tx_en        (tx_en),
    .fifo_q       (fifo_q),
    .fifo_empty   (fifo_empty),
    .fifo_rdreq   (fifo_rdreq),
    .ft_txe_i     (ft_txe_i),
    .ft_adbus_o   (ft_adbus_o),
    .ft_wr_n_o    (ft_wr_n_o),
    .ft_siwu_n_o  (ft_siwu_n_o),
    .tx_busy      (tx_busy),
    .tx_byte_cnt  (tx_byte_cnt)
  );

  ft_tx_ctrl #(.SKID_DEPTH(DEPTH), .CNT_W(4), .FLUSH_IDLE(16)) dut4 (
    .ft_shift_clk (clk),
    .rst_n        (rst_n),
    .tx_en        (tx_en),
    .fifo_q       (fifo_q),
    .fifo_empty   (fifo_empty),
    .fifo_rdreq   (rdreq4),
    .ft_txe_i     (ft_txe_i),
    .ft_adbus_o   (adbus4),
    .ft_wr_n_o    (wr_n4),
    .ft_siwu_n_o  (siwu4),
    .tx_busy      (busy4),
    .tx_byte_cnt  (cnt4)
  );

  // Behavioural FIFO: mem/wr_idx written by the stimulus, rd_idx by reads.
  logic [7:0] mem [4096];
  int         wr_idx = 0;
  int         rd_idx = 0;

  assign fifo_empty = (rd_idx == wr_idx);

  always @(posedge clk) begin
    if (fifo_rdreq) begin
      fifo_q <= mem[rd_idx];
      rd_idx <= rd_idx + 1;
    end
  end

  // Scoreboard state
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_idx = 0;
  int accepts = 0;
  int reqs = 0;
  int first_acc = 0;
  int last_acc = 0;
  int siwu_lows = 0;
  int siwu_at = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] v);
    mem[wr_idx] = v;
    wr_idx++;
  endtask

  // One clock: sample settled outputs mid-cycle (an accept observed here
  // takes effect at the coming rising edge), then return at the negedge.
  task automatic step();
    #1;
    if (rst_n) begin
      if (!ft_wr_n_o && !ft_txe_i) begin
        chk("data", {56'd0, ft_adbus_o}, {56'd0, mem[exp_idx]});
        if (accepts == 0) first_acc = cyc;
        exp_idx++;
        accepts++;
        last_acc = cyc;
      end
      if (fifo_rdreq) begin
        reqs++;
        chk("occ_bound", ((reqs - accepts) <= DEPTH), 1);
      end
      if (!ft_siwu_n_o) begin
        siwu_lows++;
        siwu_at = cyc;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    chk({tag, "_rdreq"}, fifo_rdreq, 0);
    chk({tag, "_adbus"}, ft_adbus_o, 0);
    chk({tag, "_wr_n"}, ft_wr_n_o, 1);
    chk({tag, "_siwu"}, ft_siwu_n_o, 1);
    chk({tag, "_busy"}, tx_busy, 0);
    chk({tag, "_cnt"}, tx_byte_cnt, 0);
  endtask

  // Reset the DUT and the model; leftover FIFO content is discarded unless keep_fifo.
  task automatic do_reset(input bit keep_fifo);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step();
    if (!keep_fifo) wr_idx = rd_idx;
    rst_n = 1'b1;
    exp_idx = rd_idx;
    accepts = 0;
    reqs = 0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3; i++) step();
    for (int i = 0; i < budget; i++) begin
      #1;
      if (!tx_busy && ft_wr_n_o) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk({tag, "_idle_timeout"}, done, 1);
  endtask

  task automatic wait_accepts(input int n, input int budget, input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (accepts >= n) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk({tag, "_acc_timeout"}, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n_rand;
    int k;
    int acc0;
    int req0;
    int remaining;
    logic [7:0] held_data;
    logic       held_wr;

    rst_n = 1'b0;
    tx_en = 1'b1;
    ft_txe_i = 1'b0;
    @(negedge clk);

    // Reset values with FIFO preloaded and streaming enabled
    for (int v = 0; v < 10; v++) push_byte(8'(v));
    for (int i = 0; i < 3; i++) step();
    check_reset_outputs("rst");

    // Burst of 0x00..0x09 with TXE# low
    rst_n = 1'b1;
    exp_idx = rd_idx;
    wait_idle(80, "t1");
    chk("t1_accepts", accepts, 10);
    chk("t1_cnt", tx_byte_cnt, 10);
    chk("t1_burst_span", last_acc - first_acc, 9);
    chk("t1_wr_n", ft_wr_n_o, 1);
    chk("t1_busy", tx_busy, 0);

    // TXE# high for 7 cycles mid-burst
    do_reset(1'b0);
    for (int v = 0; v < 20; v++) push_byte(8'(8'h40 + v));
    wait_accepts(5, 40, "t2");
    ft_txe_i = 1'b1;
    #1;
    held_data = ft_adbus_o;
    held_wr = ft_wr_n_o;
    chk("t2_wr_low_at_pause", held_wr, 0);
    for (int i = 0; i < 7; i++) begin
      step();
      #1;
      chk("t2_hold_data", ft_adbus_o, held_data);
      chk("t2_hold_wr", ft_wr_n_o, held_wr);
    end
    chk("t2_rdreq_full", fifo_rdreq, 0);
    chk("t2_outstanding", reqs - accepts, DEPTH);
    ft_txe_i = 1'b0;
    wait_idle(120, "t2");
    chk("t2_accepts", accepts, 20);
    chk("t2_cnt", tx_byte_cnt, 20);

    // TXE# toggling every cycle over a 16-bit ramp (low byte first)
    do_reset(1'b0);
    base = $urandom_range(0, 65535);
    for (int w = 0; w < 100; w++) begin
      push_byte(8'((base + w) & 255));
      push_byte(8'(((base + w) >> 8) & 255));
    end
    ft_txe_i = 1'($urandom_range(0, 1));
    for (int i = 0; i < 1200; i++) begin
      if (accepts >= 200) break;
      step();
      ft_txe_i = ~ft_txe_i;
    end
    ft_txe_i = 1'b0;
    wait_idle(80, "t3");
    chk("t3_accepts", accepts, 200);
    chk("t3_cnt", tx_byte_cnt, 200);
    chk("t3_cnt4", cnt4, 200 % 16);

    // Random TXE# and random FIFO refills
    do_reset(1'b0);
    n_rand = 0;
    for (int i = 0; i < 700; i++) begin
      ft_txe_i = 1'($urandom_range(0, 1));
      if (n_rand < 150 && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(1, 3);
        for (int j = 0; j < k; j++) begin
          push_byte(8'($urandom_range(0, 255)));
          n_rand++;
        end
      end
      step();
    end
    ft_txe_i = 1'b0;
    wait_idle(120, "t4");
    chk("t4_accepts", accepts, n_rand);
    chk("t4_cnt", tx_byte_cnt, n_rand);

    // tx_en dropped with 3 bytes buffered and 1 in flight
    do_reset(1'b0);
    ft_txe_i = 1'b1;
    for (int v = 0; v < 3; v++) push_byte(8'(8'hA0 + v));
    for (int i = 0; i < 6; i++) step();
    chk("t5_three_buffered", reqs, 3);
    for (int v = 3; v < 9; v++) push_byte(8'(8'hA0 + v));
    step();
    tx_en = 1'b0;
    chk("t5_outstanding", reqs - accepts, 4);
    acc0 = accepts;
    req0 = reqs;
    ft_txe_i = 1'b0;
    wait_idle(80, "t5");
    chk("t5_extra_accepts", accepts - acc0, 4);
    chk("t5_no_rdreq", reqs - req0, 0);
    chk("t5_fifo_left", wr_idx - rd_idx, 5);
    chk("t5_busy", tx_busy, 0);
    tx_en = 1'b1;

    // Counter wrap with a 4-bit counter: 18 bytes
    do_reset(1'b0);
    for (int v = 0; v < 18; v++) push_byte(8'($urandom_range(0, 255)));
    wait_idle(100, "t6");
    chk("t6_cnt4", cnt4, 2);
    chk("t6_cnt", tx_byte_cnt, 18);
    chk("t6_wr_n4", wr_n4, 1);

    // Reset mid-transfer: buffered bytes dropped, outputs back to reset at once
    do_reset(1'b0);
    for (int v = 0; v < 12; v++) push_byte(8'(8'hC0 + v));
    wait_accepts(3, 40, "t7");
    rst_n = 1'b0;
    check_reset_outputs("t7_rst");
    step();
    step();
    rst_n = 1'b1;
    exp_idx = rd_idx;
    accepts = 0;
    reqs = 0;
    remaining = wr_idx - rd_idx;
    wait_idle(80, "t7");
    chk("t7_accepts", accepts, remaining);
    chk("t7_cnt", tx_byte_cnt, remaining);

    // Send-immediate: 5 bytes then an empty FIFO
`ifdef FT_SIWU_EN
    siwu_lows = 0;
`endif
    do_reset(1'b0);
    for (int v = 0; v < 5; v++) push_byte(8'(8'h10 + v));
    wait_idle(100, "t8");
    for (int i = 0; i < 10; i++) step();
    chk("t8_accepts", accepts, 5);
`ifdef FT_SIWU_EN
    chk("t8_siwu_pulses", siwu_lows, 1);
    // Accept sampled at step k lands on the edge closing step k; the pulse
    // is then seen 16 cycles later, in step k+17.
    chk("t8_siwu_delay", siwu_at - last_acc, 17);
`else
    chk("t8_siwu_pulses", siwu_lows, 0);
`endif
    chk("t8_siwu_end", ft_siwu_n_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
